mux2_rr_arbiter: RTL
====================

# mux2_rr_arbiter

Two-requester round-robin arbiter that shares one WIDTH-bit output channel. It uses a valid/ready handshake with packet locking. It produces the 2:1 mux select internally, registers the selected beat into a single output stage, and holds a grant for the whole packet until the last beat is accepted. It sits upstream of any single-consumer datapath that two producers must share.

## Interface
- WIDTH, 8, data width of each requester and of the output
- CNT_W, 16, width of the completed-packet counter
- clk_i  input  1  clock; all state updates on the rising edge
- rst_ni  input  1  reset; asynchronous assert, active-low
- a_valid_i  input  1  requester A has a beat
- a_data_i  input  WIDTH  requester A beat data
- a_last_i  input  1  requester A beat ends its packet
- a_ready_o  output  1  requester A beat accepted this cycle when a_valid_i is also high
- b_valid_i  input  1  requester B has a beat
- b_data_i  input  WIDTH  requester B beat data
- b_last_i  input  1  requester B beat ends its packet
- b_ready_o  output  1  requester B beat accepted this cycle when b_valid_i is also high
- y_valid_o  output  1  registered output beat valid
- y_data_o  output  WIDTH  registered output data
- y_last_o  output  1  registered output last flag
- y_src_o  output  1  source of the registered beat (1 = A, 0 = B)
- y_ready_i  input  1  consumer accepts the output beat
- sel_o  output  1  current grant (1 = A, 0 = B); combinational
- busy_o  output  1  high while in LOCK_A or LOCK_B
- pkt_cnt_o  output  CNT_W  count of last beats accepted at the inputs; wraps

## Operation
- Output slot is free when !y_valid_o || y_ready_i. All input ready signals are low when the slot is not free.
- A priority pointer prio holds the preferred side (1 = A).
- FSM states:
  - IDLE: if exactly one valid is high, that side is granted. If both are high, the prio side is granted. If neither is high, sel_o = prio.
  - LOCK_A: only A is granted. sel_o = 1 and b_ready_o = 0, regardless of b_valid_i.
  - LOCK_B: only B is granted. sel_o = 0 and a_ready_o = 0.
- x_ready_o = (granted side is x) && slot free.
- Accept = granted valid && granted ready. On accept, the output register loads the granted data, last flag and source, and y_valid_o is set to 1.
- If the slot is free and nothing is accepted, y_valid_o is cleared to 0.
- Transitions on accept with last = 0: IDLE → LOCK_x (x = granted side); LOCK_x stays in LOCK_x.
- Transitions on accept with last = 1: the next state is IDLE, prio is set to the other side, and pkt_cnt_o increments modulo 2^CNT_W.
- prio changes only on an accepted last beat.
- A locked requester that drops valid keeps the lock; the other side waits indefinitely. There is no timeout.
- busy_o = (state != IDLE).

## Timing
- Reset values:
  - state = IDLE, prio = 1 (A).
  - y_valid_o = 0, y_data_o = 0, y_last_o = 0, y_src_o = 0, pkt_cnt_o = 0.
  - busy_o = 0; sel_o = 1 with no requests.
- Latency: an input accepted in cycle n appears on y_* in cycle n+1.
- Throughput: one beat per cycle while y_ready_i is held high.
- While y_valid_o && !y_ready_i, all of y_data_o, y_last_o and y_src_o are stable, and both input readies are 0.
- A y_ready_i rise in cycle n enables an input accept in the same cycle n. The ready path is combinational from y_ready_i.
- A single-beat packet, accepted in IDLE with last = 1, stays in IDLE. The flipped prio applies from the next cycle.
- Reset asserted mid-packet takes effect immediately. Any held output beat is discarded, and the lock and prio return to their reset values.
- pkt_cnt_o wraps from 2^CNT_W−1 to 0 with no flag.

## Test plan
- Reset, then A sends 1 beat 0x11 (last = 1) with y_ready_i = 1 → a_ready_o = 1 in cycle 0; y_valid_o = 1, y_data_o = 0x11, y_src_o = 1 in cycle 1; pkt_cnt_o = 1.
- A and B both valid with single-beat packets, 4 cycles, y_ready_i = 1 → outputs alternate A, B, A, B, starting with A (prio reset = A).
- A starts a 3-beat packet 0xA0, 0xA1, 0xA2 (last on the third beat) while B is valid throughout → B is blocked and busy_o = 1 during the packet. B's beat appears only after 0xA2 has been output, and busy_o = 0 after the last beat is accepted.
- Output holding beat 0x55 with y_ready_i = 0 for 3 cycles → y_data_o = 0x55 stable, a_ready_o = b_ready_o = 0. On y_ready_i = 1, the next beat is accepted in the same cycle.
- rst_ni pulsed low during LOCK_B with y_valid_o = 1 → y_valid_o = 0 and busy_o = 0 immediately. The next simultaneous request grants A.
- CNT_W = 2: 5 single-beat packets → pkt_cnt_o reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and its single consumer.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             a_valid_i;
    logic [WIDTH-1:0] a_data_i;
    logic             a_last_i;
    logic             a_ready_o;
    logic             b_valid_i;
    logic [WIDTH-1:0] b_data_i;
    logic             b_last_i;
    logic             b_ready_o;
    logic             y_valid_o;
    logic [WIDTH-1:0] y_data_o;
    logic             y_last_o;
    logic             y_src_o;
    logic             y_ready_i;
    logic             sel_o;
    logic             busy_o;
    logic [CNT_W-1:0] pkt_cnt_o;

    modport master (
        output a_valid_i, a_data_i, a_last_i, b_valid_i, b_data_i, b_last_i, y_ready_i,
        input  a_ready_o, b_ready_o, y_valid_o, y_data_o, y_last_o, y_src_o,
               sel_o, busy_o, pkt_cnt_o
    );

    modport slave (
        input  a_valid_i, a_data_i, a_last_i, b_valid_i, b_data_i, b_last_i, y_ready_i,
        output a_ready_o, b_ready_o, y_valid_o, y_data_o, y_last_o, y_src_o,
               sel_o, busy_o, pkt_cnt_o
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter with packet locking and one registered output stage.
module mux2_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic              clk_i,
    input logic              rst_ni,
    mux2_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             sel;
    logic             slot_free;
    logic             g_valid;
    logic             g_last;
    logic             accept;
    logic             y_valid_q;
    logic [WIDTH-1:0] y_data_q;
    logic             y_last_q;
    logic             y_src_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        sel       = prio_q;
        slot_free = !y_valid_q || bus.y_ready_i;
        case (state_q)
            // A lone requester wins outright; ties fall back to the priority pointer
            IDLE:    if (bus.a_valid_i != bus.b_valid_i) sel = bus.a_valid_i;
            LOCK_A:  sel = 1'b1;
            LOCK_B:  sel = 1'b0;
            default: sel = prio_q;
        endcase
        g_valid = sel ? bus.a_valid_i : bus.b_valid_i;
        g_last  = sel ? bus.a_last_i  : bus.b_last_i;
        accept  = g_valid && slot_free;
        if (accept) begin
            if (g_last) begin
                state_d = IDLE;
                prio_d  = !sel;
            end else begin
                state_d = sel ? LOCK_A : LOCK_B;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            prio_q    <= 1'b1;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_last_q  <= 1'b0;
            y_src_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (accept) begin
                y_valid_q <= 1'b1;
                y_data_q  <= sel ? bus.a_data_i : bus.b_data_i;
                y_last_q  <= g_last;
                y_src_q   <= sel;
            end else if (slot_free) begin
                y_valid_q <= 1'b0;
            end
            if (accept && g_last) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.a_ready_o = sel && slot_free;
    assign bus.b_ready_o = !sel && slot_free;
    assign bus.y_valid_o = y_valid_q;
    assign bus.y_data_o  = y_data_q;
    assign bus.y_last_o  = y_last_q;
    assign bus.y_src_o   = y_src_q;
    assign bus.sel_o     = sel;
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.pkt_cnt_o = cnt_q;
endmodule
